// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the multiplier-sharing arbiter slice.
// Holds the fp16 word type, special encodings and a constant clog2 helper.
package fp16_pkg;

  localparam int unsigned FP16_W    = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [4:0]  FP16_EMAX = 5'h1F;

  typedef logic [FP16_W-1:0] fp16_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp16_mul.sv
// Combinational IEEE binary16 multiply: round-to-nearest-even, subnormals in and out,
// overflow to infinity, canonical quiet NaN 16'h7E00 for NaN operands and inf*0.
module fp16_mul
  import fp16_pkg::*;
(
  input  fp16_t i_a,
  input  fp16_t i_b,
  output fp16_t o_p
);

  logic        w_sa, w_sb, w_s;
  logic [4:0]  w_ea, w_eb;
  logic [9:0]  w_fa, w_fb;
  logic        w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic [10:0] w_ma, w_mb;
  logic [5:0]  w_eau, w_ebu;
  logic [21:0] w_p, w_pn;
  logic [4:0]  w_lz;
  logic signed [7:0] w_be, w_ef;
  logic [3:0]  w_sh;
  logic [35:0] w_wide;
  logic [10:0] w_mant;
  logic        w_rnd;
  logic [11:0] w_mr;

  assign {w_sa, w_ea, w_fa} = i_a;
  assign {w_sb, w_eb, w_fb} = i_b;
  assign w_s = w_sa ^ w_sb;

  assign w_zero_a = (w_ea == 5'd0) && (w_fa == 10'd0);
  assign w_zero_b = (w_eb == 5'd0) && (w_fb == 10'd0);
  assign w_inf_a  = (w_ea == FP16_EMAX) && (w_fa == 10'd0);
  assign w_inf_b  = (w_eb == FP16_EMAX) && (w_fb == 10'd0);
  assign w_nan_a  = (w_ea == FP16_EMAX) && (w_fa != 10'd0);
  assign w_nan_b  = (w_eb == FP16_EMAX) && (w_fb != 10'd0);

  assign w_ma  = {(w_ea != 5'd0), w_fa};
  assign w_mb  = {(w_eb != 5'd0), w_fb};
  assign w_eau = (w_ea == 5'd0) ? 6'd1 : {1'b0, w_ea};
  assign w_ebu = (w_eb == 5'd0) ? 6'd1 : {1'b0, w_eb};

  assign w_p = {11'd0, w_ma} * {11'd0, w_mb};

  always_comb begin
    w_lz = '0;
    for (int unsigned i = 0; i < 22; i++) begin
      if (w_p[5'(i)]) w_lz = 5'(21 - i);
    end
  end

  // Normalise the product so bit 21 is the leading one; w_be is the biased result exponent.
  assign w_pn = w_p << w_lz;
  assign w_be = $signed({2'b00, w_eau}) + $signed({2'b00, w_ebu})
              - $signed({3'b000, w_lz}) - 8'sd14;

  always_comb begin
    if (w_be > 8'sd0)         w_sh = 4'd0;
    else if (w_be < -8'sd12)  w_sh = 4'd14;
    else                      w_sh = 4'(8'sd1 - w_be);
  end

  assign w_wide = {w_pn, 14'd0} >> w_sh;
  assign w_mant = w_wide[35:25];
  assign w_rnd  = w_wide[24] & ((|w_wide[23:0]) | w_mant[0]);
  assign w_mr   = {1'b0, w_mant} + {11'd0, w_rnd};

  // A subnormal that rounds up into bit 10 becomes the smallest normal.
  assign w_ef = (w_be > 8'sd0) ? (w_be + $signed({7'd0, w_mr[11]}))
                               : $signed({7'd0, w_mr[10]});

  always_comb begin
    if (w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b))
      o_p = FP16_QNAN;
    else if (w_inf_a || w_inf_b)
      o_p = {w_s, FP16_EMAX, 10'd0};
    else if (w_zero_a || w_zero_b)
      o_p = {w_s, FP16_ZERO[14:0]};
    else if (w_ef > 8'sd30)
      o_p = {w_s, FP16_EMAX, 10'd0};
    else
      o_p = {w_s, w_ef[4:0], w_mr[9:0]};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr (modulo NUM_REQ).
// Produces a one-hot grant and its encoded index; nothing is granted while i_en is low.
module rr_arbiter
  import fp16_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned w_i;
      w_i = 32'(i_ptr) + k;
      if (w_i >= NUM_REQ) w_i = w_i - NUM_REQ;
      if (!w_found && i_en && i_req[ID_W'(w_i)]) begin
        w_found              = 1'b1;
        o_gnt[ID_W'(w_i)]    = 1'b1;
        o_idx                = ID_W'(w_i);
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one fp16 multiplier between NUM_REQ lanes with round-robin grant and a tagged result.
// Define FP16_MUL_PIPE_EN to add an operand register stage ahead of the multiplier (latency 2).
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FP16_W-1:0] req_a,
  input  logic [NUM_REQ*FP16_W-1:0] req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [FP16_W-1:0]         res_data,
  output logic [ID_W-1:0]           res_id,
  output logic [15:0]               ops_count
);

  fp16_t             w_lane_a [NUM_REQ];
  fp16_t             w_lane_b [NUM_REQ];
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_next_ptr;
  logic              w_xfer;
  logic              w_acc;
  logic              w_drain;
  fp16_t             w_mul_a, w_mul_b, w_prod;

  logic [ID_W-1:0]   r_ptr;
  logic              r_res_valid;
  fp16_t             r_res_data;
  logic [ID_W-1:0]   r_res_id;
  logic [15:0]       r_ops;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_lane_a[g] = req_a[g*FP16_W +: FP16_W];
    assign w_lane_b[g] = req_b[g*FP16_W +: FP16_W];
  end

  // Reset gates the grant combinationally so no transfer is offered during reset.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_acc & rst_n),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  assign req_ready  = w_gnt;
  assign w_xfer     = |(w_gnt & req_valid);
  assign w_drain    = r_res_valid & res_ready;
  assign w_next_ptr = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  fp16_mul u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

`ifdef FP16_MUL_PIPE_EN
  logic              r_in_valid;
  fp16_t             r_in_a, r_in_b;
  logic [ID_W-1:0]   r_in_id;
  logic              w_out_adv;

  assign w_out_adv = !r_res_valid | res_ready;
  assign w_acc     = !r_in_valid | w_out_adv;
  assign w_mul_a   = r_in_a;
  assign w_mul_b   = r_in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_valid  <= 1'b0;
      r_in_a      <= FP16_ZERO;
      r_in_b      <= FP16_ZERO;
      r_in_id     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= FP16_ZERO;
      r_res_id    <= '0;
    end else begin
      if (w_acc) begin
        r_in_valid <= w_xfer;
        if (w_xfer) begin
          r_in_a  <= w_lane_a[w_gnt_idx];
          r_in_b  <= w_lane_b[w_gnt_idx];
          r_in_id <= w_gnt_idx;
        end
      end
      if (w_out_adv) begin
        r_res_valid <= r_in_valid;
        if (r_in_valid) begin
          r_res_data <= w_prod;
          r_res_id   <= r_in_id;
        end
      end
    end
  end
`else
  assign w_acc   = !r_res_valid | res_ready;
  assign w_mul_a = w_lane_a[w_gnt_idx];
  assign w_mul_b = w_lane_b[w_gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= FP16_ZERO;
      r_res_id    <= '0;
    end else if (w_xfer) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_prod;
      r_res_id    <= w_gnt_idx;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_ops <= '0;
    end else begin
      if (w_xfer)  r_ptr <= w_next_ptr;
      if (w_drain) r_ops <= r_ops + 16'd1;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign ops_count = r_ops;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Randomised bench for fp16_mul_arbiter against a queue-based model with a real-arithmetic fp16 reference.
module tb_fp16_mul_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef FP16_MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_a = '0;
  logic [N*16-1:0] req_b = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [15:0]     res_data;
  logic [IDW-1:0]  res_id;
  logic [15:0]     ops_count;

  fp16_mul_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester side: each lane holds valid and operands until it is granted.
  logic [N-1:0] lv;
  logic [15:0]  la [N];
  logic [15:0]  lb [N];
  logic         rdy;
  logic [N-1:0] seen_ready;

  // Model: results in flight in issue order, at most LAT of them.
  typedef struct { logic [15:0] d; int id; int t; } item_t;
  item_t       q[$];
  int          ptr;
  int          cyc;
  logic [15:0] ops;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else        repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int e, f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) return f * pow2(-24);
    return (1024 + f) * pow2(e - 25);
  endfunction

  // Exact product in double, then round-to-nearest-even onto the fp16 grid.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    logic za, zb, ia, ib, na, nb;
    real  x, qv, rem;
    int   e, m;
    s  = a[15] ^ b[15];
    za = (a[14:0] == 15'd0);
    zb = (b[14:0] == 15'd0);
    ia = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    ib = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    na = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    if (na || nb || (ia && zb) || (za && ib)) return 16'h7E00;
    if (ia || ib) return {s, 15'h7C00};
    if (za || zb) return {s, 15'h0000};
    x = h2r(a) * h2r(b);
    e = 0;
    while (x >= pow2(e + 1)) e++;
    while (x < pow2(e)) e--;
    if (e < -14) e = -14;
    qv  = x / pow2(e - 10);
    m   = $rtoi(qv);
    rem = qv - m;
    if (rem > 0.5 || (rem == 0.5 && (m % 2) == 1)) m++;
    if (m == 2048) begin m = 1024; e++; end
    if (e > 15) return {s, 15'h7C00};
    if (m >= 1024) return {s, 5'(e + 15), 10'(m - 1024)};
    return {s, 5'd0, 10'(m)};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0:       r = {r[15], 15'd0};
      1:       ;
      2:       r = {r[15], 5'd0, r[9:0]};
      3:       r = {r[15], 5'($urandom_range(25, 30)), r[9:0]};
      4:       r = {r[15], 5'($urandom_range(1, 6)), r[9:0]};
      default: r = {r[15], 5'($urandom_range(8, 22)), r[9:0]};
    endcase
    return r;
  endfunction

  function automatic logic head_vis();
    return (q.size() > 0) && ((cyc - q[0].t) >= LAT - 1);
  endfunction

  task automatic refill(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!lv[i] && ($urandom_range(0, 99) < pct)) begin
        lv[i] = 1'b1;
        la[i] = rnd_op();
        lb[i] = rnd_op();
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = la[i];
      req_b[i*16 +: 16] = lb[i];
    end
    req_valid = lv;
    res_ready = rdy;
  endtask

  // One clock: starts and ends at a negedge; checks grant, then registered outputs.
  task automatic tick();
    logic         vis, acc;
    logic [N-1:0] g;
    int           gi;
    item_t        it;
    apply();
    #1;
    vis = head_vis();
    acc = (q.size() < LAT) || (vis && rdy);
    g   = '0;
    gi  = -1;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (gi < 0 && lv[i]) begin gi = i; g[i] = 1'b1; end
      end
    end
    seen_ready = req_ready;
    chk("req_ready", req_ready, g);
    @(posedge clk);
    cyc++;
    if (vis && rdy) begin
      void'(q.pop_front());
      ops++;
    end
    if (gi >= 0) begin
      it.d = ref_mul(la[gi], lb[gi]);
      it.id = gi;
      it.t = cyc;
      q.push_back(it);
      ptr = (gi + 1) % N;
      lv[gi] = 1'b0;
    end
    @(negedge clk);
    vis = head_vis();
    chk("res_valid", res_valid, vis);
    if (vis) begin
      chk("res_data", res_data, q[0].d);
      chk("res_id", res_id, q[0].id);
    end
    chk("ops_count", ops_count, ops);
  endtask

  // Async reset with lanes requesting; outputs must clear without waiting for a clock.
  task automatic do_reset();
    lv = '1;
    for (int i = 0; i < N; i++) begin la[i] = rnd_op(); lb[i] = rnd_op(); end
    apply();
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 16'h0000);
    chk("rst_res_id", res_id, 0);
    chk("rst_ops", ops_count, 16'h0000);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_edge_ready", req_ready, 0);
    chk("rst_edge_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ptr = 0;
    ops = 16'h0000;
  endtask

  task automatic issue_one(input int lane, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_d, input logic [15:0] exp_ops);
    rdy = 1'b1;
    lv = '0;
    lv[lane] = 1'b1;
    la[lane] = a;
    lb[lane] = b;
    tick();
    repeat (LAT - 1) tick();
    chk("dir_res_valid", res_valid, 1);
    chk("dir_res_data", res_data, exp_d);
    chk("dir_res_id", res_id, lane);
    tick();
    chk("dir_ops", ops_count, exp_ops);
  endtask

  initial begin
    lv = '0;
    rdy = 1'b1;
    for (int i = 0; i < N; i++) begin la[i] = 16'h0; lb[i] = 16'h0; end
    ptr = 0; cyc = 0; ops = 16'h0;
    apply();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    issue_one(2, 16'h3C00, 16'h4000, 16'h4000, 16'd1);
    issue_one(0, 16'h0000, 16'h4500, 16'h0000, 16'd2);
    issue_one(1, 16'hBC00, 16'h3C00, 16'hBC00, 16'd3);
    issue_one(3, 16'h4200, 16'h4200, 16'h4880, 16'd4);

    // Fairness from a fresh reset: grants walk 0,1,2,3 and wrap.
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      refill(100);
      tick();
      chk("rr_order", seen_ready, 4'b0001 << (k % 4));
    end

    // Backpressure: nothing granted while the result is stuck.
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      refill(100);
      tick();
      chk("bp_ready", seen_ready, 0);
      chk("bp_valid", res_valid, 1);
    end
    rdy = 1'b1;
    repeat (6) begin refill(100); tick(); end
    repeat (4) tick();

    // Reset while a result is pending; first grant afterwards is lane 0.
    repeat (2) begin refill(100); tick(); end
    rdy = 1'b0;
    repeat (2) begin refill(100); tick(); end
    do_reset();
    rdy = 1'b1;
    tick();
    chk("post_rst_grant", seen_ready, 4'b0001);

    for (int k = 0; k < 3000; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      refill((k % 500) < 450 ? 50 : 0);
      tick();
    end

    // Counter wrap: 65536 handshakes bring ops_count back to zero.
    do_reset();
    rdy = 1'b1;
    for (int it = 0; it < 70000 && ops != 16'hFFFF; it++) begin
      for (int i = 0; i < N; i++) if (!lv[i]) begin lv[i] = 1'b1; la[i] = 16'h3C00; lb[i] = 16'h4000; end
      tick();
    end
    chk("wrap_pre", ops_count, 16'hFFFF);
    for (int i = 0; i < N; i++) if (!lv[i]) begin lv[i] = 1'b1; la[i] = 16'h3C00; lb[i] = 16'h4000; end
    tick();
    chk("wrap_zero", ops_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
